// File: rtl/banked_address_decoder_if.sv
// ---------------------------------------------------------------------------
// banked_address_decoder_if
// Request/response bundle between the control sequencer (master) and the
// banked register-select decoder (slave).
//   In_Address      : flat address, bank*P_RegCount + reg
//   In_Write        : 1 = write access, 0 = read access
//   In_Valid        : request valid
//   Out_Ready       : decoder can accept a request
//   Out_BankSelect  : one-hot bank select
//   Out_WriteSelect : one-hot register write strobe
//   Out_ReadSelect  : one-hot register read strobe
//   Out_Ack         : one-cycle access-complete pulse
//   Out_Error       : qualifies Out_Ack, address was out of range
//   Out_ErrorCount  : saturating count of out-of-range accesses
// ---------------------------------------------------------------------------
interface banked_address_decoder_if #(
    parameter int unsigned P_RegCount  = 8,
    parameter int unsigned P_BankCount = 2
);
    localparam int unsigned AW = $clog2(P_RegCount * P_BankCount);

    logic [AW-1:0]          In_Address;
    logic                   In_Write;
    logic                   In_Valid;
    logic                   Out_Ready;
    logic [P_BankCount-1:0] Out_BankSelect;
    logic [P_RegCount-1:0]  Out_WriteSelect;
    logic [P_RegCount-1:0]  Out_ReadSelect;
    logic                   Out_Ack;
    logic                   Out_Error;
    logic [7:0]             Out_ErrorCount;

    modport master (
        output In_Address, In_Write, In_Valid,
        input  Out_Ready, Out_BankSelect, Out_WriteSelect, Out_ReadSelect,
        input  Out_Ack, Out_Error, Out_ErrorCount
    );

    modport slave (
        input  In_Address, In_Write, In_Valid,
        output Out_Ready, Out_BankSelect, Out_WriteSelect, Out_ReadSelect,
        output Out_Ack, Out_Error, Out_ErrorCount
    );
endinterface

// File: rtl/banked_address_decoder.sv
// ---------------------------------------------------------------------------
// banked_address_decoder
// Registered, handshaked register-select decoder. Accepts one request at a
// time, splits the flat address into bank and register index, drives one-hot
// bank/write/read selects and acknowledges the access. Out-of-range accesses
// skip the strobe and are acknowledged with Out_Error and counted.
// Ports:
//   In_Clock : clock, rising edge
//   In_Reset : asynchronous, active-high reset
//   bus      : banked_address_decoder_if slave modport (request/response)
// Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module banked_address_decoder #(
    parameter int unsigned P_RegCount  = 8,
    parameter int unsigned P_BankCount = 2,
    parameter bit          P_HoldMode  = 1'b0
) (
    input  logic                     In_Clock,
    input  logic                     In_Reset,
    banked_address_decoder_if.slave  bus
);
    localparam int unsigned TOTAL = P_RegCount * P_BankCount;
    localparam int unsigned AW    = $clog2(TOTAL);
    localparam int unsigned BW    = (P_BankCount > 1) ? $clog2(P_BankCount) : 1;
    localparam int unsigned RW    = $clog2(P_RegCount);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [AW-1:0]          addr_q;
    logic                   write_q;
    logic                   ready_q;
    logic [P_BankCount-1:0] bank_sel_q;
    logic [P_RegCount-1:0]  wr_sel_q;
    logic [P_RegCount-1:0]  rd_sel_q;
    logic                   ack_q;
    logic                   error_q;
    logic [7:0]             err_cnt_q;

    logic [BW-1:0]          bank_idx_s;
    logic [RW-1:0]          reg_idx_s;
    logic                   oob_s;
    logic [P_BankCount-1:0] bank_oh_s;
    logic [P_RegCount-1:0]  reg_oh_s;

    // Split the latched address into bank/register and build the one-hot codes.
    // The index values are only meaningful when oob_s is 0.
    always_comb begin
        oob_s      = (32'(addr_q) >= TOTAL);
        bank_idx_s = BW'(32'(addr_q) / P_RegCount);
        reg_idx_s  = RW'(32'(addr_q) % P_RegCount);
        bank_oh_s  = {P_BankCount{1'b0}};
        reg_oh_s   = {P_RegCount{1'b0}};
        for (int unsigned b = 0; b < P_BankCount; b++) begin
            bank_oh_s[b] = (32'(bank_idx_s) == b);
        end
        for (int unsigned r = 0; r < P_RegCount; r++) begin
            reg_oh_s[r] = (32'(reg_idx_s) == r);
        end
    end

    // Access FSM with registered selects, ack/error, ready and error counter.
    always_ff @(posedge In_Clock or posedge In_Reset) begin
        if (In_Reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= {AW{1'b0}};
            write_q    <= 1'b0;
            ready_q    <= 1'b0;
            bank_sel_q <= {P_BankCount{1'b0}};
            wr_sel_q   <= {P_RegCount{1'b0}};
            rd_sel_q   <= {P_RegCount{1'b0}};
            ack_q      <= 1'b0;
            error_q    <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            // Ack/Error are single-cycle pulses unless set below.
            ack_q   <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!ready_q) begin
                        // First cycle after reset release: raise ready only.
                        ready_q <= 1'b1;
                    end else if (bus.In_Valid) begin
                        addr_q  <= bus.In_Address;
                        write_q <= bus.In_Write;
                        ready_q <= 1'b0;
                        state_q <= ST_DECODE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DECODE: begin
                    if (oob_s) begin
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end else begin
                            err_cnt_q <= err_cnt_q;
                        end
                        ack_q   <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        bank_sel_q <= bank_oh_s;
                        wr_sel_q   <= write_q ? reg_oh_s : {P_RegCount{1'b0}};
                        rd_sel_q   <= write_q ? {P_RegCount{1'b0}} : reg_oh_s;
                        state_q    <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (P_HoldMode && bus.In_Valid) begin
                        // Hold: selects stay frozen on the latched access.
                        state_q <= ST_STROBE;
                    end else begin
                        bank_sel_q <= {P_BankCount{1'b0}};
                        wr_sel_q   <= {P_RegCount{1'b0}};
                        rd_sel_q   <= {P_RegCount{1'b0}};
                        ack_q      <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    bank_sel_q <= {P_BankCount{1'b0}};
                    wr_sel_q   <= {P_RegCount{1'b0}};
                    rd_sel_q   <= {P_RegCount{1'b0}};
                    ready_q    <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Out_Ready       = ready_q;
    assign bus.Out_BankSelect  = bank_sel_q;
    assign bus.Out_WriteSelect = wr_sel_q;
    assign bus.Out_ReadSelect  = rd_sel_q;
    assign bus.Out_Ack         = ack_q;
    assign bus.Out_Error       = error_q;
    assign bus.Out_ErrorCount  = err_cnt_q;
endmodule

// File: tb/tb_banked_address_decoder.sv
// ---------------------------------------------------------------------------
// tb_banked_address_decoder
// Self-checking bench: a pulse-mode decoder (dut0) and a hold-mode decoder
// (dut1), both 6 registers x 3 banks. Directed vector table, random accesses
// against an arithmetic reference model, error-counter saturation,
// back-to-back throughput, hold-mode strobe length and mid-access reset.
// ---------------------------------------------------------------------------
module tb_banked_address_decoder;
    localparam int unsigned RC = 6;
    localparam int unsigned BC = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    banked_address_decoder_if #(.P_RegCount(RC), .P_BankCount(BC)) if0 ();
    banked_address_decoder_if #(.P_RegCount(RC), .P_BankCount(BC)) if1 ();

    banked_address_decoder #(.P_RegCount(RC), .P_BankCount(BC), .P_HoldMode(1'b0)) dut0 (
        .In_Clock (clk),
        .In_Reset (rst),
        .bus      (if0.slave)
    );

    banked_address_decoder #(.P_RegCount(RC), .P_BankCount(BC), .P_HoldMode(1'b1)) dut1 (
        .In_Clock (clk),
        .In_Reset (rst),
        .bus      (if1.slave)
    );

    typedef struct {
        logic [4:0] addr;
        logic       wr;
        logic [2:0] bank;
        logic [5:0] wsel;
        logic [5:0] rsel;
        logic       err;
    } vec_t;

    int tests     = 0;
    int fails     = 0;
    int model_err = 0;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: decode straight from the address arithmetic.
    function automatic vec_t model(input logic [4:0] a, input logic w);
        vec_t v;
        int   ai;
        ai     = int'(a);
        v.addr = a;
        v.wr   = w;
        v.bank = 3'b000;
        v.wsel = 6'b000000;
        v.rsel = 6'b000000;
        v.err  = (ai >= int'(RC * BC));
        if (!v.err) begin
            v.bank = 3'(1 << (ai / int'(RC)));
            if (w) v.wsel = 6'(1 << (ai % int'(RC)));
            else   v.rsel = 6'(1 << (ai % int'(RC)));
        end
        return v;
    endfunction

    function automatic logic [31:0] sel0();
        return 32'({if0.Out_BankSelect, if0.Out_WriteSelect, if0.Out_ReadSelect});
    endfunction

    function automatic logic [31:0] sel1();
        return 32'({if1.Out_BankSelect, if1.Out_WriteSelect, if1.Out_ReadSelect});
    endfunction

    // One complete access on dut0, checked cycle by cycle (called at a negedge).
    task automatic access(input vec_t v);
        int n;
        n = 0;
        while (if0.Out_Ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(if0.Out_Ready), 32'd1);
        if0.In_Address = v.addr;
        if0.In_Write   = v.wr;
        if0.In_Valid   = 1'b1;
        @(negedge clk);
        if0.In_Valid   = 1'b0;
        if0.In_Address = ~v.addr;
        if0.In_Write   = ~v.wr;
        check("decode_ready", 32'(if0.Out_Ready), 32'd0);
        check("decode_sel", sel0(), 32'd0);
        check("decode_ack", 32'(if0.Out_Ack), 32'd0);
        @(negedge clk);
        if (!v.err) begin
            check("strobe_bank", 32'(if0.Out_BankSelect), 32'(v.bank));
            check("strobe_wsel", 32'(if0.Out_WriteSelect), 32'(v.wsel));
            check("strobe_rsel", 32'(if0.Out_ReadSelect), 32'(v.rsel));
            check("strobe_ack", 32'(if0.Out_Ack), 32'd0);
            @(negedge clk);
        end else begin
            if (model_err < 255) model_err++;
        end
        check("ack", 32'(if0.Out_Ack), 32'd1);
        check("ack_error", 32'(if0.Out_Error), 32'(v.err));
        check("ack_sel", sel0(), 32'd0);
        check("err_count", 32'(if0.Out_ErrorCount), 32'(model_err));
        @(negedge clk);
        check("ack_drop", 32'(if0.Out_Ack), 32'd0);
        check("ready_back", 32'(if0.Out_Ready), 32'd1);
    endtask

    // Hold-mode access on dut1: In_Valid stays high for h extra STROBE edges.
    task automatic hold_access(input logic [4:0] a, input logic w, input int h);
        vec_t v;
        int   n;
        v = model(a, w);
        n = 0;
        while (if1.Out_Ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("hold_ready_wait", 32'(if1.Out_Ready), 32'd1);
        if1.In_Address = a;
        if1.In_Write   = w;
        if1.In_Valid   = 1'b1;
        @(negedge clk);
        if1.In_Address = 5'($urandom);
        check("hold_decode_sel", sel1(), 32'd0);
        @(negedge clk);
        check("hold_strobe_sel", sel1(), 32'({v.bank, v.wsel, v.rsel}));
        for (int k = 0; k < h; k++) begin
            if1.In_Address = 5'($urandom);
            if1.In_Write   = ~w;
            @(negedge clk);
            check("hold_strobe_frozen", sel1(), 32'({v.bank, v.wsel, v.rsel}));
            check("hold_no_ack", 32'(if1.Out_Ack), 32'd0);
        end
        if1.In_Valid = 1'b0;
        @(negedge clk);
        check("hold_ack", 32'(if1.Out_Ack), 32'd1);
        check("hold_ack_error", 32'(if1.Out_Error), 32'd0);
        check("hold_ack_sel", sel1(), 32'd0);
        @(negedge clk);
        check("hold_ack_drop", 32'(if1.Out_Ack), 32'd0);
        check("hold_ready_back", 32'(if1.Out_Ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int accepts;
        vec_t v;

        rst = 1'b1;
        if0.In_Valid = 1'b0; if0.In_Address = 5'd0; if0.In_Write = 1'b0;
        if1.In_Valid = 1'b0; if1.In_Address = 5'd0; if1.In_Write = 1'b0;

        vecs[0] = '{5'd13, 1'b1, 3'b100, 6'b000010, 6'b000000, 1'b0};
        vecs[1] = '{5'd0,  1'b0, 3'b001, 6'b000000, 6'b000001, 1'b0};
        vecs[2] = '{5'd20, 1'b1, 3'b000, 6'b000000, 6'b000000, 1'b1};
        vecs[3] = '{5'd17, 1'b1, 3'b100, 6'b100000, 6'b000000, 1'b0};
        vecs[4] = '{5'd6,  1'b0, 3'b010, 6'b000000, 6'b000001, 1'b0};
        vecs[5] = '{5'd18, 1'b0, 3'b000, 6'b000000, 6'b000000, 1'b1};
        vecs[6] = '{5'd11, 1'b0, 3'b010, 6'b000000, 6'b100000, 1'b0};
        vecs[7] = '{5'd31, 1'b1, 3'b000, 6'b000000, 6'b000000, 1'b1};

        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(if0.Out_Ready), 32'd0);
        check("rst_sel", sel0(), 32'd0);
        check("rst_ack", 32'({if0.Out_Ack, if0.Out_Error}), 32'd0);
        check("rst_cnt", 32'(if0.Out_ErrorCount), 32'd0);
        check("rst_ready_hold", 32'(if1.Out_Ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(if0.Out_Ready), 32'd1);

        for (int i = 0; i < 8; i++) access(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            access(model(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1))));
        end

        for (int i = 0; i < 300; i++) begin
            access(model(5'($urandom_range(18, 31)), 1'($urandom_range(0, 1))));
        end
        check("err_saturated", 32'(if0.Out_ErrorCount), 32'd255);

        // In_Valid stuck high: an accept every 4 cycles, ready only in IDLE.
        last    = -1;
        accepts = 0;
        if0.In_Address = 5'd2;
        if0.In_Write   = 1'b0;
        if0.In_Valid   = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (if0.Out_Ready === 1'b1) begin
                if (last >= 0) check("b2b_spacing", 32'(c - last), 32'd4);
                check("b2b_idle_sel", sel0(), 32'd0);
                check("b2b_idle_ack", 32'(if0.Out_Ack), 32'd0);
                last = c;
                accepts++;
            end
            @(negedge clk);
        end
        if0.In_Valid = 1'b0;
        check("b2b_accepts", 32'(accepts), 32'd5);

        hold_access(5'd7, 1'b1, 4);
        hold_access(5'd3, 1'b0, 0);

        // Reset in the middle of a STROBE.
        @(negedge clk);
        v = model(5'd13, 1'b1);
        if0.In_Address = 5'd13;
        if0.In_Write   = 1'b1;
        if0.In_Valid   = 1'b1;
        @(negedge clk);
        if0.In_Valid = 1'b0;
        @(negedge clk);
        check("mid_strobe_sel", sel0(), 32'({v.bank, v.wsel, v.rsel}));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sel", sel0(), 32'd0);
        check("mid_rst_ack", 32'({if0.Out_Ack, if0.Out_Error}), 32'd0);
        check("mid_rst_cnt", 32'(if0.Out_ErrorCount), 32'd0);
        check("mid_rst_ready", 32'(if0.Out_Ready), 32'd0);
        model_err = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_no_ack", 32'(if0.Out_Ack), 32'd0);
        access(vecs[1]);
        access(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
